// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: drives the flush/stall controls of
// every pipeline register and the PC, defers taken branches behind in-flight fetches, and counts stalls/flushes.
module hazard_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000,
  parameter int unsigned           CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            id_rs1_addr,
  input  logic [4:0]            id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [4:0]            ex_rd_addr,
  input  logic                  ex_MemRead,
  input  logic                  ex_branch_taken,
  input  logic [ADDR_WIDTH-1:0] ex_branch_target,
  input  logic                  if_busy,
  input  logic                  mem_busy,
  output logic [1:0]            ifid_flush_and_stall,
  output logic [1:0]            idex_flush_and_stall,
  output logic [1:0]            exmem_flush_and_stall,
  output logic [1:0]            memwb_flush_and_stall,
  output logic                  pc_stall,
  output logic                  pc_redirect,
  output logic [ADDR_WIDTH-1:0] pc_redirect_target,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  typedef enum logic {RUN, PEND} state_e;

  localparam logic [1:0] FLUSH = 2'b10;
  localparam logic [1:0] STALL = 2'b01;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, flush_cnt_q;
  logic                  load_use;

  assign load_use = ex_MemRead && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    ifid_flush_and_stall  = 2'b00;
    idex_flush_and_stall  = 2'b00;
    exmem_flush_and_stall = 2'b00;
    memwb_flush_and_stall = 2'b00;
    pc_stall              = 1'b0;
    pc_redirect           = 1'b0;
    pc_redirect_target    = target_q;
    state_d               = state_q;
    target_d              = target_q;

    if (reset) begin
      state_d  = RUN;
      target_d = PC_ADDR;
    end else if (mem_busy) begin
      // A data wait freezes everything up to MEM; a pending branch stays parked in EX.
      pc_stall              = 1'b1;
      ifid_flush_and_stall  = STALL;
      idex_flush_and_stall  = STALL;
      exmem_flush_and_stall = STALL;
      memwb_flush_and_stall = FLUSH;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken && !if_busy) begin
            pc_redirect          = 1'b1;
            pc_redirect_target   = ex_branch_target;
            ifid_flush_and_stall = FLUSH;
            idex_flush_and_stall = FLUSH;
          end else if (ex_branch_taken) begin
            pc_stall             = 1'b1;
            ifid_flush_and_stall = FLUSH;
            idex_flush_and_stall = FLUSH;
            target_d             = ex_branch_target;
            state_d              = PEND;
          end else if (load_use) begin
            pc_stall             = 1'b1;
            ifid_flush_and_stall = STALL;
            idex_flush_and_stall = FLUSH;
          end else if (if_busy) begin
            pc_stall             = 1'b1;
            ifid_flush_and_stall = FLUSH;
          end
        end
        PEND: begin
          // Only bubbles trail the deferred branch, so EX-side hazards are irrelevant here.
          ifid_flush_and_stall = FLUSH;
          if (if_busy) begin
            pc_stall = 1'b1;
          end else begin
            pc_redirect = 1'b1;
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      target_q    <= PC_ADDR;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if (pc_stall) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (ifid_flush_and_stall[1]) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32 core. It drives the 2-bit flush_and_stall control of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC stall and redirect.
- It resolves load-use hazards, taken-branch redirects, and fetch/data memory wait states.
- Its sequential logic comes from three sources: a redirect-pending FSM that defers a taken branch while an instruction fetch is in flight, a captured redirect target, and two performance counters.

Parameters:
- PC_ADDR, 32'h8000_0000, reset value of the captured redirect target.
- ADDR_WIDTH, 32, PC and target width.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_rs1_addr  in  5  rs1 index of the instruction in ID
- id_rs2_addr  in  5  rs2 index of the instruction in ID
- id_uses_rs1  in  1  the ID instruction reads rs1
- id_uses_rs2  in  1  the ID instruction reads rs2
- ex_rd_addr  in  5  rd index held in the ID/EX register
- ex_MemRead  in  1  the ID/EX instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- ex_branch_target  in  ADDR_WIDTH  resolved target address
- if_busy  in  1  instruction fetch outstanding (no ack yet)
- mem_busy  in  1  MEM-stage data access outstanding
- ifid_flush_and_stall  out  2  IF/ID control; bit1 = flush, bit0 = stall
- idex_flush_and_stall  out  2  ID/EX control; same encoding
- exmem_flush_and_stall  out  2  EX/MEM control; same encoding
- memwb_flush_and_stall  out  2  MEM/WB control; same encoding
- pc_stall  out  1  hold the PC
- pc_redirect  out  1  load the PC from pc_redirect_target this cycle
- pc_redirect_target  out  ADDR_WIDTH  redirect address
- stall_cycles  out  CNT_WIDTH  count of cycles with pc_stall=1
- flush_count  out  CNT_WIDTH  count of cycles with ifid flush=1

Behaviour:
- **Reset.** All state updates on posedge clk only.
  - On reset=1: FSM goes to RUN, target_q=PC_ADDR, both counters=0.
  - While reset=1, every *_flush_and_stall output is 2'b00, and pc_stall=0, pc_redirect=0.
  - pc_redirect_target=target_q whenever not redirecting directly.
- **Outputs are combinational** from the FSM state and the inputs, with zero latency. Any output not named in a rule below is 2'b00 / 0.
- **Load-use hazard:** lu = ex_MemRead && ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==ex_rd_addr)).
- **FSM states:** RUN and PEND (a taken redirect is waiting for the in-flight fetch to finish).
- **Rules in RUN, highest priority first:**
  1. mem_busy: pc_stall=1; ifid, idex and exmem = 01; memwb = 10. ex_branch_taken is ignored; EX holds, so the branch is re-seen later.
  2. ex_branch_taken && !if_busy: pc_redirect=1, pc_redirect_target=ex_branch_target; ifid=10, idex=10. State stays RUN.
  3. ex_branch_taken && if_busy: pc_stall=1; ifid=10, idex=10; target_q<=ex_branch_target; next state PEND.
  4. lu: pc_stall=1; ifid=01; idex=10.
  5. if_busy: pc_stall=1; ifid=10 (insert a bubble, since there is no valid fetch).
  6. Otherwise all outputs 00.
- **Rules in PEND:**
  - mem_busy: same outputs as RUN rule 1; state and target_q held.
  - else if if_busy: pc_stall=1; ifid=10; stay in PEND.
  - else (fetch done): pc_redirect=1, target=target_q; ifid=10 to discard the wrong-path fetch; next state RUN.
  - ex_branch_taken and lu are ignored in PEND, because the pipe behind the branch holds only bubbles.
- **Counters:**
  - stall_cycles increments on each cycle with pc_stall=1.
  - flush_count increments on each cycle with ifid bit1=1.
  - Both wrap modulo 2^CNT_WIDTH and do not count while reset=1.
- **Mid-operation reset:** reset asserted during PEND returns to RUN and drops the pending redirect.

Test Plan:
1. Load-use: ex_MemRead=1, ex_rd_addr=5, id_rs2_addr=5, id_uses_rs2=1 -> ifid=01, idex=10, pc_stall=1, stall_cycles +1. The same stimulus with ex_rd_addr=0 -> all outputs 00.
2. Taken branch, fetch idle: ex_branch_taken=1, target=0x8000_0040, if_busy=0 -> pc_redirect=1, pc_redirect_target=0x8000_0040, ifid=10, idex=10, flush_count +1.
3. Taken branch, fetch busy for 3 cycles, target 0x8000_0100:
   - Cycle 0: ifid=10, idex=10, pc_stall=1.
   - Cycles 1-2: ifid=10, pc_stall=1.
   - Cycle 3 (if_busy=0): pc_redirect=1 with target 0x8000_0100.
   - ex_branch_target changed to 0 during PEND has no effect on the redirect target.
4. mem_busy held 2 cycles together with ex_branch_taken=1:
   - Both cycles: ifid, idex and exmem = 01, memwb=10, pc_stall=1, no redirect.
   - Third cycle: the redirect issues.
5. mem_busy rising during PEND with if_busy=0: state held, no redirect. mem_busy falls -> pc_redirect=1 with target_q.
6. Reset asserted in PEND: all outputs 0 during reset. After release, if_busy=0 and no branch -> no redirect; counters read 0.
